// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
// Moore-style main control unit for the multi-cycle 32-bit MIPS datapath.
// It walks each instruction through fetch, decode, execute, memory and
// writeback states, and drives every datapath enable and mux select.
//
// Ports:
//   clk       system clock, all state changes on the rising edge
//   reset     synchronous, active-high; forces all outputs low while high
//   Opcode    IR[31:26] of the instruction held in the IR
//   Zero      ALU zero flag, used in the branch-completion cycle
//   PCEn      PC load enable (unconditional write or taken branch)
//   PCSource  PC source mux: 00 PC+4, 01 branch target, 10 jump address
//   IorD      memory address select (0 = PC, 1 = ALUOut)
//   MemRead   memory read strobe
//   MemWrite  memory write strobe
//   IRWrite   instruction register load
//   MemtoReg  register write data from MDR
//   RegDst    destination register (1 = rd, 0 = rt)
//   RegWrite  register file write
//   ALUSrcA   ALU A select (0 = PC, 1 = rs)
//   ALUSrcB   ALU B select (00 rt, 01 const 4, 10 imm, 11 imm << 2)
//   ALUOp     00 add, 01 subtract, 10 funct-decoded
//   Illegal   one-cycle pulse in DECODE for an unsupported opcode
//   State     current state encoding, for debug
module multicycle_control_fsm #(
  parameter int STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [5:0]             Opcode,
  input  logic                   Zero,
  output logic                   PCEn,
  output logic [1:0]             PCSource,
  output logic                   IorD,
  output logic                   MemRead,
  output logic                   MemWrite,
  output logic                   IRWrite,
  output logic                   MemtoReg,
  output logic                   RegDst,
  output logic                   RegWrite,
  output logic                   ALUSrcA,
  output logic [1:0]             ALUSrcB,
  output logic [1:0]             ALUOp,
  output logic                   Illegal,
  output logic [STATE_WIDTH-1:0] State
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  typedef enum logic [STATE_WIDTH-1:0] {
    FETCH    = STATE_WIDTH'(0),
    DECODE   = STATE_WIDTH'(1),
    MEMADDR  = STATE_WIDTH'(2),
    MEMREAD  = STATE_WIDTH'(3),
    MEMWB    = STATE_WIDTH'(4),
    MEMWRITE = STATE_WIDTH'(5),
    EXEC     = STATE_WIDTH'(6),
    RWB      = STATE_WIDTH'(7),
    BRANCH   = STATE_WIDTH'(8),
    JUMP     = STATE_WIDTH'(9),
    ADDIEXEC = STATE_WIDTH'(10),
    ADDIWB   = STATE_WIDTH'(11)
  } state_t;

  state_t state_q;
  state_t state_d;
  logic   pcwrite;
  logic   pcwritecond;
  logic   branch_cond;

  // State register; reset aborts whatever instruction is in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and state-decoded outputs. Everything is held low while
  // reset is high so no strobe can fire in the reset cycle.
  always_comb begin
    state_d     = FETCH;
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    PCSource    = 2'b00;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    Illegal     = 1'b0;
    if (!reset) begin
      case (state_q)
        FETCH: begin
          MemRead = 1'b1;
          IRWrite = 1'b1;
          pcwrite = 1'b1;
          ALUSrcB = 2'b01;
          state_d = DECODE;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          case (Opcode)
            OP_LW, OP_SW:     state_d = MEMADDR;
            OP_R:             state_d = EXEC;
            OP_BEQ, OP_BNE:   state_d = BRANCH;
            OP_J:             state_d = JUMP;
            OP_ADDI:          state_d = ADDIEXEC;
            default: begin
              state_d = FETCH;
              Illegal = 1'b1;
            end
          endcase
        end
        MEMADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = (Opcode == OP_LW) ? MEMREAD : MEMWRITE;
        end
        MEMREAD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
          state_d = MEMWB;
        end
        MEMWB: begin
          RegWrite = 1'b1;
          MemtoReg = 1'b1;
        end
        MEMWRITE: begin
          MemWrite = 1'b1;
          IorD     = 1'b1;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
          state_d = RWB;
        end
        RWB: begin
          RegWrite = 1'b1;
          RegDst   = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          pcwritecond = 1'b1;
          PCSource    = 2'b01;
        end
        JUMP: begin
          pcwrite  = 1'b1;
          PCSource = 2'b10;
        end
        ADDIEXEC: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          state_d = ADDIWB;
        end
        ADDIWB: begin
          RegWrite = 1'b1;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // BNE takes the branch on a non-zero difference, BEQ on zero.
  assign branch_cond = (Opcode == OP_BNE) ? ~Zero : Zero;
  assign PCEn        = pcwrite | (pcwritecond & branch_cond);
  assign State       = reset ? '0 : state_q;

endmodule
